// File: rtl/cpu_pkg.sv
// cpu_pkg: shared exception cause codes, PC mux selects and exception-unit states
package cpu_pkg;
    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_OPCODE = 2'd1;
    localparam logic [1:0] CAUSE_OVF    = 2'd2;
    localparam logic [1:0] CAUSE_DIV0   = 2'd3;
    localparam logic [2:0] PCSRC_NONE   = 3'd0;
    localparam logic [2:0] PCSRC_EPC    = 3'd4;
    localparam logic [2:0] PCSRC_EXC    = 3'd5;
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_JUMP, S_RET} exc_state_t;
endpackage

// File: rtl/exception_unit.sv
// exception_unit: saves EPC, fetches the handler byte from the vector table and requests PC loads
module exception_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] VEC_BASE    = 32'd252,
    parameter int          MEM_LATENCY = 1,
    parameter logic [31:0] PC_STEP     = 32'd4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_in,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic        rfe,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] epc,
    output logic [31:0] handler_addr,
    output logic [2:0]  pc_source,
    output logic        pc_write,
    output logic        busy,
    output logic [1:0]  cause
);
    exc_state_t r_state, w_next;
    logic [2:0] r_cnt;
    logic       w_exc;
    logic [1:0] w_cause;
    logic       w_unused;

    assign w_unused = ^mem_data[31:8];
    assign w_exc    = exc_opcode | exc_overflow | exc_divzero;
    assign w_cause  = exc_opcode ? CAUSE_OPCODE : exc_overflow ? CAUSE_OVF : CAUSE_DIV0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_exc ? S_REQ : rfe ? S_RET : S_IDLE;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  w_next = (r_cnt <= 3'd1) ? S_JUMP : S_WAIT;
            default: w_next = S_IDLE;
        endcase
    end

    // epc only loads from IDLE, so a nested exception cannot clobber it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            epc          <= 32'd0;
            handler_addr <= 32'd0;
            mem_addr     <= 32'd0;
            cause        <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_exc) begin
                cause    <= w_cause;
                epc      <= pc_in - PC_STEP;
                mem_addr <= VEC_BASE + {30'd0, w_cause};
            end
            if (r_state == S_REQ)
                r_cnt <= 3'(MEM_LATENCY);
            if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt <= 3'd1)
                    handler_addr <= {24'd0, mem_data[7:0]};
            end
        end
    end

    assign mem_rd    = r_state == S_REQ;
    assign pc_write  = r_state == S_JUMP || r_state == S_RET;
    assign pc_source = r_state == S_JUMP ? PCSRC_EXC : r_state == S_RET ? PCSRC_EPC : PCSRC_NONE;
    assign busy      = r_state != S_IDLE;
endmodule

// File: tb/tb_exception_unit.sv
// tb_exception_unit: table-driven vectors with a pc_write scoreboard, plus latency-3 and reset corner cases
module tb_exception_unit;
    logic clk = 1'b0, reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] pc_in = 32'd0, pc3 = 32'd0;
    logic op = 1'b0, ov = 1'b0, dz = 1'b0, rfe = 1'b0, op3 = 1'b0, zero = 1'b0;
    logic [31:0] mem_data, mem_addr, epc, handler_addr;
    logic [31:0] mem_data3, mem_addr3, epc3, handler_addr3;
    logic [2:0] pc_source, pc_source3;
    logic [1:0] cause, cause3;
    logic mem_rd, pc_write, busy, mem_rd3, pc_write3, busy3;

    exception_unit dut (
        .clk(clk), .reset_n(reset_n), .pc_in(pc_in), .exc_opcode(op), .exc_overflow(ov),
        .exc_divzero(dz), .rfe(rfe), .mem_data(mem_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .epc(epc), .handler_addr(handler_addr), .pc_source(pc_source), .pc_write(pc_write),
        .busy(busy), .cause(cause)
    );

    exception_unit #(.MEM_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .pc_in(pc3), .exc_opcode(op3), .exc_overflow(zero),
        .exc_divzero(zero), .rfe(zero), .mem_data(mem_data3), .mem_addr(mem_addr3), .mem_rd(mem_rd3),
        .epc(epc3), .handler_addr(handler_addr3), .pc_source(pc_source3), .pc_write(pc_write3),
        .busy(busy3), .cause(cause3)
    );

    // memory returns the vector byte only in the cycle it is due; other cycles return junk
    function automatic logic [7:0] vec_byte(input logic [31:0] a);
        case (a)
            32'd253: return 8'h80;
            32'd254: return 8'h90;
            32'd255: return 8'hA0;
            default: return 8'h5A;
        endcase
    endfunction

    logic [7:0] hist1, hist3;
    always @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hist1 <= 8'd0;
            hist3 <= 8'd0;
        end else begin
            hist1 <= {hist1[6:0], mem_rd};
            hist3 <= {hist3[6:0], mem_rd3};
        end
    assign mem_data  = hist1[0] ? {24'hFFFFFF, vec_byte(mem_addr)} : 32'h0000_00EE;
    assign mem_data3 = hist3[2] ? {24'hFFFFFF, vec_byte(mem_addr3)} : 32'h0000_00EE;

    int n_chk = 0, n_fail = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]  src;
        logic [31:0] epc;
        logic [31:0] hnd;
        logic [1:0]  cause;
    } exp_t;
    exp_t q[$];
    exp_t e;

    always @(negedge clk)
        if (pc_write) begin
            if (q.size() == 0) check("unexpected_pc_write", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                check("sb_pc_source", {29'd0, pc_source}, {29'd0, e.src});
                check("sb_epc", epc, e.epc);
                check("sb_handler", handler_addr, e.hnd);
                check("sb_cause", {30'd0, cause}, {30'd0, e.cause});
            end
        end

    int n_wr3 = 0;
    always @(negedge clk) if (pc_write3) n_wr3++;

    typedef struct {
        logic op, ov, dz, rfe, poke;
        logic [31:0] pc;
        logic [1:0]  cause;
        logic [31:0] epc, addr, hnd;
        logic [2:0]  src;
    } vec_t;

    task automatic run(input vec_t t);
        int t_rd = 0, t_wr = 0, n = 20;
        logic x;
        x = t.op | t.ov | t.dz;
        @(negedge clk);
        {op, ov, dz, rfe} = {t.op, t.ov, t.dz, t.rfe};
        pc_in = t.pc;
        q.push_back(exp_t'{t.src, t.epc, t.hnd, t.cause});
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            {op, ov, dz, rfe} = 4'b0;
            if (t.poke && k == 1) begin
                op = 1'b1;
                pc_in = 32'h500;
            end
            if (mem_rd) begin
                t_rd = k;
                check("mem_addr_at_rd", mem_addr, t.addr);
            end
            if (pc_write) t_wr = k;
            if (!busy) begin
                n = k;
                break;
            end
        end
        check("busy_release", {31'd0, busy}, 32'd0);
        check("mem_rd_cycle", t_rd, x ? 32'd1 : 32'd0);
        check("pc_write_cycle", t_wr, x ? 32'd3 : 32'd1);
        check("busy_cycles", n, x ? 32'd4 : 32'd2);
        check("epc", epc, t.epc);
        check("cause", {30'd0, cause}, {30'd0, t.cause});
        check("handler", handler_addr, t.hnd);
        check("mem_addr", mem_addr, t.addr);
        check("queue_drained", q.size(), 32'd0);
        @(negedge clk);
        check("not_queued", {31'd0, busy}, 32'd0);
    endtask

    vec_t v[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40,  2'd1, 32'h3C,       32'd253, 32'h80, 3'd5};
        v[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h999, 2'd1, 32'h3C,       32'd253, 32'h80, 3'd4};
        v[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 2'd2, 32'h1FC,      32'd254, 32'h90, 3'd5};
        v[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,   2'd3, 32'hFFFFFFFC, 32'd255, 32'hA0, 3'd5};
        v[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h8,   2'd1, 32'h4,        32'd253, 32'h80, 3'd5};
        v[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h77,  2'd1, 32'h4,        32'd253, 32'h80, 3'd4};

        @(negedge clk);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_handler", handler_addr, 32'd0);
        check("rst_flags", {28'd0, mem_rd, pc_write, busy, 1'b0}, 32'd0);
        check("rst_pc_source", {29'd0, pc_source}, 32'd0);
        check("rst_cause", {30'd0, cause}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run(v[i]);

        begin
            int t_rd = 0, t_wr = 0, n = 20;
            @(negedge clk);
            op3 = 1'b1;
            pc3 = 32'h100;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                op3 = 1'b0;
                if (mem_rd3) t_rd = k;
                if (pc_write3) begin
                    t_wr = k;
                    check("l3_pc_source", {29'd0, pc_source3}, 32'd5);
                end
                if (!busy3) begin
                    n = k;
                    break;
                end
            end
            check("l3_mem_rd_cycle", t_rd, 32'd1);
            check("l3_pc_write_cycle", t_wr, 32'd5);
            check("l3_busy_cycles", n, 32'd6);
            check("l3_epc", epc3, 32'hFC);
            check("l3_handler", handler_addr3, 32'h80);
            check("l3_mem_addr", mem_addr3, 32'd253);
        end

        begin
            int base;
            @(negedge clk);
            op3 = 1'b1;
            repeat (3) begin
                @(negedge clk);
                op3 = 1'b0;
            end
            check("l3_mid_wait_busy", {31'd0, busy3}, 32'd1);
            base = n_wr3;
            reset_n = 1'b0;
            #1;
            check("arst_mem_addr", mem_addr3, 32'd0);
            check("arst_epc", epc3, 32'd0);
            check("arst_handler", handler_addr3, 32'd0);
            check("arst_flags", {29'd0, mem_rd3, pc_write3, busy3}, 32'd0);
            check("arst_pc_source", {29'd0, pc_source3}, 32'd0);
            check("arst_cause", {30'd0, cause3}, 32'd0);
            check("arst_dut1_epc", epc, 32'd0);
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
            repeat (8) @(negedge clk);
            check("arst_no_pc_write", n_wr3 - base, 32'd0);
            check("arst_idle", {31'd0, busy3}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Multicycle exception sequencer for the MIPS-style CPU datapath.
- Directly upstream of the PC-source multiplexer: supplies the saved EPC (PCSource=4 input) and the handler address (PCSource=5 input).
- On a detected exception it:
  - saves the return PC;
  - reads the 8-bit handler address from a fixed memory vector;
  - requests the PC load.
- It also services return-from-exception by requesting PC <= EPC.

Parameters:
- VEC_BASE, 32'd252, base of exception vector table; vector byte address = VEC_BASE + cause.
- MEM_LATENCY, 1, cycles from the mem_rd cycle until mem_data is valid (1..7).
- PC_STEP, 32'd4, amount subtracted from pc_in to form EPC.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc_in  in  32  current PC register value (already incremented).
- exc_opcode  in  1  invalid-opcode flag from control unit, sampled when idle.
- exc_overflow  in  1  ALU overflow flag, sampled when idle.
- exc_divzero  in  1  divide-by-zero flag, sampled when idle.
- rfe  in  1  return-from-exception request, sampled when idle.
- mem_data  in  32  memory read data; only bits [7:0] are used.
- mem_addr  out  32  vector address driven to memory mux.
- mem_rd  out  1  memory read strobe.
- epc  out  32  saved exception PC; feeds PC mux input 4.
- handler_addr  out  32  zero-extended handler address; feeds PC mux input 5.
- pc_source  out  3  PC mux select request: 4 = EPC, 5 = handler, else 0.
- pc_write  out  1  one-cycle PC write enable.
- busy  out  1  high in any state other than IDLE; control unit stalls while high.
- cause  out  2  last exception cause: 0 none, 1 opcode, 2 overflow, 3 divzero.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, wait counter=0.
  - epc, handler_addr, mem_addr = 0.
  - mem_rd, pc_write, busy = 0; pc_source=0; cause=0.
- States: IDLE, REQ, WAIT, JUMP, RET. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - If any exc_* is high at the clock edge:
    - Priority is opcode > overflow > divzero; lower-priority flags raised in the same cycle are dropped.
    - cause <= winner; epc <= pc_in - PC_STEP (mod 2^32, so pc_in=0 gives 32'hFFFFFFFC).
    - mem_addr <= VEC_BASE + cause; go to REQ.
  - Else if rfe=1: go to RET.
  - If an exception and rfe arrive together, the exception wins and rfe is dropped.
- REQ: mem_rd=1 for exactly one cycle; mem_addr held; load wait counter with MEM_LATENCY; go to WAIT.
- WAIT:
  - Decrement the counter each cycle; mem_addr held; mem_rd=0.
  - On the edge where the counter reaches 1: handler_addr <= {24'b0, mem_data[7:0]}; go to JUMP.
  - WAIT lasts exactly MEM_LATENCY cycles.
- JUMP: pc_source=5, pc_write=1 for one cycle; go to IDLE.
- RET: pc_source=4, pc_write=1 for one cycle; epc unchanged; go to IDLE.
- busy=1 in REQ, WAIT, JUMP and RET.
- exc_* and rfe are ignored while busy; they are not queued. The control unit must hold them if it needs them serviced.
- A nested exception cannot overwrite epc until the unit returns to IDLE.
- Latency with MEM_LATENCY=1: flag sampled at edge 0, then REQ in cycle 1, WAIT in cycle 2, and pc_write in cycle 3 (3 cycles after the flag edge). The RFE path takes 1 cycle.
- Reset mid-sequence: all state is lost, including epc; the PC write is not issued.
- VEC_BASE + cause wraps modulo 2^32 and is not checked.

Decomposition:
- Shared package (cpu_pkg) holds:
  - the cause encodings (CAUSE_NONE, CAUSE_OPCODE, CAUSE_OVF, CAUSE_DIV0);
  - the PC mux select constants (PCSRC_EPC=4, PCSRC_EXC=5);
  - the exception-unit state enum.
- Single module, no sub-module; the latency counter is inline (3 bits).

Test Plan:
1. Reset, then exc_opcode=1 for one cycle with pc_in=0x00000040 and mem_data[7:0]=0x80 at address 253 → epc=0x3C, cause=1, mem_rd pulses with mem_addr=253, handler_addr=0x00000080, pc_write=1 with pc_source=5 exactly 3 cycles after the flag.
2. exc_overflow and exc_divzero together, with memory byte 254=0x90 → cause=2, mem_addr=254, handler_addr=0x90, divzero dropped.
3. exc_divzero with pc_in=0 → epc=0xFFFFFFFC, mem_addr=255; a second exc_opcode pulse while busy is ignored, with exactly one pc_write and epc unchanged.
4. After scenario 1, rfe=1 in IDLE → next cycle pc_write=1, pc_source=4, epc=0x3C; busy high for one cycle.
5. With MEM_LATENCY=3, exception at pc_in=0x100 → WAIT lasts 3 cycles and pc_write comes 5 cycles after the flag; then reset_n=0 asserted mid-WAIT → all outputs are 0 immediately and no pc_write occurs.
